// File: rtl/mem_req_arbiter_pkg.sv
// Shared definitions for the memory request arbiter: bus widths, the
// load/store opcode encoding, FSM state codes and grant-owner codes.
package mem_req_arbiter_pkg;

    localparam int DAT_W = 32;
    localparam int OP_W  = 6;

    // Load/store opcodes shared with the MC
    localparam logic [OP_W-1:0] OP_LB  = 6'h00;
    localparam logic [OP_W-1:0] OP_LH  = 6'h01;
    localparam logic [OP_W-1:0] OP_LW  = 6'h02;
    localparam logic [OP_W-1:0] OP_LBU = 6'h04;
    localparam logic [OP_W-1:0] OP_LHU = 6'h05;
    localparam logic [OP_W-1:0] OP_SB  = 6'h08;
    localparam logic [OP_W-1:0] OP_SH  = 6'h09;
    localparam logic [OP_W-1:0] OP_SW  = 6'h0A;

    // Instruction fetches are always full words
    localparam logic [2:0] LEN_WORD = 3'd4;

    // FSM states
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    // Owner of the MC transaction in flight
    localparam logic OWN_IC = 1'b0;
    localparam logic OWN_DC = 1'b1;

endpackage

// File: rtl/mem_req_arbiter_req_latch.sv
// Single-entry request holder: a pending bit plus the captured address,
// data, opcode, length and write-enable of one requester.
// Clear has priority over capture; a capture while already pending is dropped.
module mem_req_arbiter_req_latch #(
    parameter int DAT_W = 32,
    parameter int OP_W  = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             set,
    input  logic             clr,
    input  logic [DAT_W-1:0] adr_i,
    input  logic [DAT_W-1:0] dat_i,
    input  logic [OP_W-1:0]  op_i,
    input  logic [2:0]       len_i,
    input  logic             we_i,
    output logic             pend_o,
    output logic [DAT_W-1:0] adr_o,
    output logic [DAT_W-1:0] dat_o,
    output logic [OP_W-1:0]  op_o,
    output logic [2:0]       len_o,
    output logic             we_o
);

    // Pending bit and captured fields
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_o <= 1'b0;
            adr_o  <= '0;
            dat_o  <= '0;
            op_o   <= '0;
            len_o  <= '0;
            we_o   <= 1'b0;
        end else if (en) begin
            if (clr) begin
                pend_o <= 1'b0;
            end else if (set && !pend_o) begin
                pend_o <= 1'b1;
                adr_o  <= adr_i;
                dat_o  <= dat_i;
                op_o   <= op_i;
                len_o  <= len_i;
                we_o   <= we_i;
            end
        end
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// Arbiter between instruction fetch (IC), load/store (DC) and the single
// byte-serial memory controller (MC). One MC transaction in flight at a time;
// completions are routed back to the issuing requester. Branch flushes squash
// fetches and loads but never stores.
// Optional: define STARVE_GUARD_EN to force an IC grant after STARVE_MAX
// consecutive DC grants taken while IC was waiting.
module mem_req_arbiter
    import mem_req_arbiter_pkg::*;
#(
    parameter int DAT_W      = mem_req_arbiter_pkg::DAT_W,
    parameter int OP_W       = mem_req_arbiter_pkg::OP_W,
    parameter int STARVE_MAX = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             br_flag,
    input  logic             ic_req_i,
    input  logic [DAT_W-1:0] ic_adr_i,
    output logic             ic_ack_o,
    output logic [DAT_W-1:0] ic_dat_o,
    input  logic             dc_req_i,
    input  logic             dc_we_i,
    input  logic [OP_W-1:0]  dc_op_i,
    input  logic [2:0]       dc_len_i,
    input  logic [DAT_W-1:0] dc_adr_i,
    input  logic [DAT_W-1:0] dc_dat_i,
    output logic             dc_ack_o,
    output logic [DAT_W-1:0] dc_dat_o,
    output logic             mc_req_o,
    output logic             mc_we_o,
    output logic [OP_W-1:0]  mc_op_o,
    output logic [2:0]       mc_len_o,
    output logic [DAT_W-1:0] mc_adr_o,
    output logic [DAT_W-1:0] mc_dat_o,
    input  logic             mc_done_i,
    input  logic [DAT_W-1:0] mc_dat_i
);

    logic             ic_pend, dc_pend;
    logic [DAT_W-1:0] ic_adr_q, ic_dat_q, dc_adr_q, dc_dat_q;
    logic [OP_W-1:0]  ic_op_q, dc_op_q;
    logic [2:0]       ic_len_q, dc_len_q;
    logic             ic_we_q, dc_we_q;

    logic [0:0]       state;
    logic             owner;
    logic             owner_we;
    logic             squash;

    logic             dc_flush;
    logic             ic_cand, dc_cand;
    logic             slot_free;
    logic             starve_hit;
    logic             grant_ic, grant_dc;
    logic             inflight_kill;
    logic             ic_clr, dc_clr, dc_set;

    mem_req_arbiter_req_latch #(.DAT_W(DAT_W), .OP_W(OP_W)) u_ic_latch (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .set    (ic_req_i),
        .clr    (ic_clr),
        .adr_i  (ic_adr_i),
        .dat_i  ('0),
        .op_i   (OP_W'(OP_LW)),
        .len_i  (LEN_WORD),
        .we_i   (1'b0),
        .pend_o (ic_pend),
        .adr_o  (ic_adr_q),
        .dat_o  (ic_dat_q),
        .op_o   (ic_op_q),
        .len_o  (ic_len_q),
        .we_o   (ic_we_q)
    );

    mem_req_arbiter_req_latch #(.DAT_W(DAT_W), .OP_W(OP_W)) u_dc_latch (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .set    (dc_set),
        .clr    (dc_clr),
        .adr_i  (dc_adr_i),
        .dat_i  (dc_dat_i),
        .op_i   (dc_op_i),
        .len_i  (dc_len_i),
        .we_i   (dc_we_i),
        .pend_o (dc_pend),
        .adr_o  (dc_adr_q),
        .dat_o  (dc_dat_q),
        .op_o   (dc_op_q),
        .len_o  (dc_len_q),
        .we_o   (dc_we_q)
    );

`ifdef STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    logic [CNT_W-1:0] starve_cnt;

    // Count DC grants taken while IC is waiting; cleared once IC is served or idle
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (en) begin
            if (!ic_cand || grant_ic) begin
                starve_cnt <= '0;
            end else if (grant_dc) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

    assign starve_hit = (starve_cnt >= CNT_W'(STARVE_MAX));
`else
    // Strict DC priority; STARVE_MAX only matters when the guard is built in
    assign starve_hit = 1'b0 & (STARVE_MAX > 0);
`endif

    // Flush filtering, arbitration and latch control
    always_comb begin
        dc_flush      = br_flag & dc_pend & ~dc_we_q;
        ic_cand       = ic_pend & ~br_flag;
        dc_cand       = dc_pend & ~dc_flush;
        // A completion frees the MC in the same cycle, so the next grant
        // can issue alongside the returning ack.
        slot_free     = (state == ST_IDLE) | mc_done_i;
        grant_ic      = en & slot_free & ic_cand & (~dc_cand | starve_hit);
        grant_dc      = en & slot_free & dc_cand & ~grant_ic;
        inflight_kill = br_flag & ((owner == OWN_IC) | ~owner_we);
        ic_clr        = grant_ic | br_flag;
        dc_clr        = grant_dc | dc_flush;
        dc_set        = dc_req_i & ~(br_flag & ~dc_we_i);
    end

    // Grant/complete FSM and registered MC / requester outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            owner    <= OWN_IC;
            owner_we <= 1'b0;
            squash   <= 1'b0;
            mc_req_o <= 1'b0;
            mc_we_o  <= 1'b0;
            mc_op_o  <= '0;
            mc_len_o <= '0;
            mc_adr_o <= '0;
            mc_dat_o <= '0;
            ic_ack_o <= 1'b0;
            ic_dat_o <= '0;
            dc_ack_o <= 1'b0;
            dc_dat_o <= '0;
        end else if (en) begin
            mc_req_o <= 1'b0;
            ic_ack_o <= 1'b0;
            dc_ack_o <= 1'b0;

            if (state == ST_WAIT) begin
                if (mc_done_i) begin
                    state  <= ST_IDLE;
                    squash <= 1'b0;
                    if (!(squash || inflight_kill)) begin
                        if (owner == OWN_IC) begin
                            ic_ack_o <= 1'b1;
                            ic_dat_o <= mc_dat_i;
                        end else begin
                            dc_ack_o <= 1'b1;
                            dc_dat_o <= mc_dat_i;
                        end
                    end
                end else if (inflight_kill) begin
                    squash <= 1'b1;
                end
            end

            if (grant_ic || grant_dc) begin
                state    <= ST_WAIT;
                squash   <= 1'b0;
                mc_req_o <= 1'b1;
                owner    <= grant_dc ? OWN_DC : OWN_IC;
                owner_we <= grant_dc ? dc_we_q  : ic_we_q;
                mc_we_o  <= grant_dc ? dc_we_q  : ic_we_q;
                mc_op_o  <= grant_dc ? dc_op_q  : ic_op_q;
                mc_len_o <= grant_dc ? dc_len_q : ic_len_q;
                mc_adr_o <= grant_dc ? dc_adr_q : ic_adr_q;
                mc_dat_o <= grant_dc ? dc_dat_q : ic_dat_q;
            end
        end
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Self-checking bench for mem_req_arbiter: directed scenarios plus randomized
// traffic compared cycle by cycle against a transaction-level reference model.
module tb_mem_req_arbiter;
    import mem_req_arbiter_pkg::*;

    localparam int DW   = 32;
    localparam int OW   = 6;
    localparam int SMAX = 4;

    logic          clk = 1'b0;
    logic          rst, en, br_flag;
    logic          ic_req_i;
    logic [DW-1:0] ic_adr_i;
    logic          ic_ack_o;
    logic [DW-1:0] ic_dat_o;
    logic          dc_req_i, dc_we_i;
    logic [OW-1:0] dc_op_i;
    logic [2:0]    dc_len_i;
    logic [DW-1:0] dc_adr_i, dc_dat_i;
    logic          dc_ack_o;
    logic [DW-1:0] dc_dat_o;
    logic          mc_req_o, mc_we_o;
    logic [OW-1:0] mc_op_o;
    logic [2:0]    mc_len_o;
    logic [DW-1:0] mc_adr_o, mc_dat_o;
    logic          mc_done_i;
    logic [DW-1:0] mc_dat_i;

    int n_pass  = 0;
    int n_total = 0;

    mem_req_arbiter #(.DAT_W(DW), .OP_W(OW), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst), .en(en), .br_flag(br_flag),
        .ic_req_i(ic_req_i), .ic_adr_i(ic_adr_i), .ic_ack_o(ic_ack_o), .ic_dat_o(ic_dat_o),
        .dc_req_i(dc_req_i), .dc_we_i(dc_we_i), .dc_op_i(dc_op_i), .dc_len_i(dc_len_i),
        .dc_adr_i(dc_adr_i), .dc_dat_i(dc_dat_i), .dc_ack_o(dc_ack_o), .dc_dat_o(dc_dat_o),
        .mc_req_o(mc_req_o), .mc_we_o(mc_we_o), .mc_op_o(mc_op_o), .mc_len_o(mc_len_o),
        .mc_adr_o(mc_adr_o), .mc_dat_o(mc_dat_o), .mc_done_i(mc_done_i), .mc_dat_i(mc_dat_i)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        logic          valid;
        logic          we;
        logic [OW-1:0] op;
        logic [2:0]    len;
        logic [DW-1:0] adr;
        logic [DW-1:0] dat;
    } req_t;

    typedef struct packed {
        logic          mc_req;
        logic          mc_we;
        logic [OW-1:0] mc_op;
        logic [2:0]    mc_len;
        logic [DW-1:0] mc_adr;
        logic [DW-1:0] mc_dat;
        logic          ic_ack;
        logic [DW-1:0] ic_dat;
        logic          dc_ack;
        logic [DW-1:0] dc_dat;
    } obs_t;

    req_t m_ic, m_dc;
    bit   m_busy, m_own_dc, m_own_store, m_squash;
    int   m_cnt;
    obs_t m_out;

    function automatic obs_t dut_obs();
        return {mc_req_o, mc_we_o, mc_op_o, mc_len_o, mc_adr_o, mc_dat_o,
                ic_ack_o, ic_dat_o, dc_ack_o, dc_dat_o};
    endfunction

    // One clock of the arbiter's rules, applied to the inputs seen at the edge
    task automatic model_step();
        bit   ic_live, dc_live, free, doomed, take_ic;
        req_t nic, ndc;
        if (rst) begin
            m_ic = '{default: '0}; m_dc = '{default: '0};
            m_busy = 0; m_own_dc = 0; m_own_store = 0; m_squash = 0; m_cnt = 0;
            m_out = '0;
            return;
        end
        if (!en) return;
        m_out.mc_req = 0; m_out.ic_ack = 0; m_out.dc_ack = 0;
        // flush drops fetches and loads still waiting
        ic_live = m_ic.valid && !br_flag;
        dc_live = m_dc.valid && !(br_flag && !m_dc.we);
        free = !m_busy;
        if (m_busy) begin
            doomed = br_flag && (!m_own_dc || !m_own_store);
            if (mc_done_i) begin
                if (!m_squash && !doomed) begin
                    if (m_own_dc) begin m_out.dc_ack = 1; m_out.dc_dat = mc_dat_i; end
                    else          begin m_out.ic_ack = 1; m_out.ic_dat = mc_dat_i; end
                end
                m_busy = 0; m_squash = 0; free = 1;
            end else if (doomed) begin
                m_squash = 1;
            end
        end
        take_ic = 0;
        if (free && (ic_live || dc_live)) begin
`ifdef STARVE_GUARD_EN
            take_ic = ic_live && (!dc_live || m_cnt >= SMAX);
`else
            take_ic = ic_live && !dc_live;
`endif
            m_out.mc_req = 1;
            m_busy = 1; m_squash = 0; m_own_dc = !take_ic;
            if (take_ic) begin
                m_out.mc_we = 0; m_out.mc_op = OP_LW; m_out.mc_len = 3'd4;
                m_out.mc_adr = m_ic.adr; m_out.mc_dat = '0; m_own_store = 0;
            end else begin
                m_out.mc_we = m_dc.we; m_out.mc_op = m_dc.op; m_out.mc_len = m_dc.len;
                m_out.mc_adr = m_dc.adr; m_out.mc_dat = m_dc.dat; m_own_store = m_dc.we;
            end
`ifdef STARVE_GUARD_EN
            if (ic_live && !take_ic) m_cnt++;
`endif
        end
        if (!ic_live || take_ic) m_cnt = 0;
        if (take_ic) ic_live = 0; else if (m_out.mc_req) dc_live = 0;
        nic = m_ic; nic.valid = ic_live;
        ndc = m_dc; ndc.valid = dc_live;
        if (!m_ic.valid && ic_req_i && !br_flag)
            nic = '{1'b1, 1'b0, OP_LW, 3'd4, ic_adr_i, '0};
        if (!m_dc.valid && dc_req_i && !(br_flag && !dc_we_i))
            ndc = '{1'b1, dc_we_i, dc_op_i, dc_len_i, dc_adr_i, dc_dat_i};
        m_ic = nic; m_dc = ndc;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic clear_inputs();
        en = 1; br_flag = 0; ic_req_i = 0; ic_adr_i = '0;
        dc_req_i = 0; dc_we_i = 0; dc_op_i = '0; dc_len_i = '0; dc_adr_i = '0; dc_dat_i = '0;
        mc_done_i = 0; mc_dat_i = '0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst = 1; tick(); tick(); rst = 0;
    endtask

    task automatic issue_fetch(input logic [DW-1:0] adr);
        ic_req_i = 1; ic_adr_i = adr; tick(); ic_req_i = 0; tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        clear_inputs();
        rst = 1; ic_req_i = 1; dc_req_i = 1; mc_done_i = 1; br_flag = 1;
        mc_dat_i = $urandom; ic_adr_i = $urandom; dc_adr_i = $urandom;
        repeat (3) tick();
        n_total++;
        if (dut_obs() !== obs_t'('0)) $display("FAIL reset_outputs: got %h want 0", dut_obs());
        else n_pass++;
        clear_inputs(); rst = 0; tick();
        n_total++;
        if (dut_obs() !== obs_t'('0)) $display("FAIL post_reset_idle: got %h want 0", dut_obs());
        else n_pass++;
    endtask

    task automatic test_ic_fetch();
        apply_reset();
        ic_req_i = 1; ic_adr_i = 32'h100; tick(); ic_req_i = 0;
        n_total++;
        if (mc_req_o !== 1'b0) $display("FAIL fetch_no_early_issue: got %b want 0", mc_req_o);
        else n_pass++;
        tick();
        n_total++;
        if ({mc_req_o, mc_we_o, mc_len_o, mc_op_o, mc_adr_o} !== {1'b1, 1'b0, 3'd4, OP_LW, 32'h100})
            $display("FAIL fetch_issue: got %b %b %0d %h %h want 1 0 4 %h 100",
                     mc_req_o, mc_we_o, mc_len_o, mc_op_o, mc_adr_o, OP_LW);
        else n_pass++;
        repeat (4) tick();
        n_total++;
        if ({mc_req_o, mc_adr_o, mc_len_o, ic_ack_o} !== {1'b0, 32'h100, 3'd4, 1'b0})
            $display("FAIL fetch_hold: got %b %h %0d %b want 0 100 4 0", mc_req_o, mc_adr_o, mc_len_o, ic_ack_o);
        else n_pass++;
        mc_done_i = 1; mc_dat_i = 32'h00112233; tick(); mc_done_i = 0;
        n_total++;
        if ({ic_ack_o, ic_dat_o, dc_ack_o} !== {1'b1, 32'h00112233, 1'b0})
            $display("FAIL fetch_ack: got %b %h %b want 1 00112233 0", ic_ack_o, ic_dat_o, dc_ack_o);
        else n_pass++;
        tick();
        n_total++;
        if ({ic_ack_o, ic_dat_o} !== {1'b0, 32'h00112233})
            $display("FAIL fetch_ack_pulse: got %b %h want 0 00112233", ic_ack_o, ic_dat_o);
        else n_pass++;
    endtask

    task automatic test_same_cycle();
        apply_reset();
        ic_req_i = 1; ic_adr_i = 32'h104;
        dc_req_i = 1; dc_we_i = 0; dc_op_i = OP_LW; dc_len_i = 3'd4; dc_adr_i = 32'h200;
        tick(); ic_req_i = 0; dc_req_i = 0;
        tick();
        n_total++;
        if ({mc_req_o, mc_we_o, mc_adr_o} !== {1'b1, 1'b0, 32'h200})
            $display("FAIL dc_first: got %b %b %h want 1 0 200", mc_req_o, mc_we_o, mc_adr_o);
        else n_pass++;
        tick(); tick();
        mc_done_i = 1; mc_dat_i = 32'hA5A50001; tick(); mc_done_i = 0;
        n_total++;
        if ({dc_ack_o, dc_dat_o, mc_req_o, mc_adr_o, mc_len_o, ic_ack_o} !==
            {1'b1, 32'hA5A50001, 1'b1, 32'h104, 3'd4, 1'b0})
            $display("FAIL ic_issue_with_dc_ack: got %b %h %b %h %0d %b want 1 a5a50001 1 104 4 0",
                     dc_ack_o, dc_dat_o, mc_req_o, mc_adr_o, mc_len_o, ic_ack_o);
        else n_pass++;
        tick();
        mc_done_i = 1; mc_dat_i = 32'h0BADF00D; tick(); mc_done_i = 0;
        n_total++;
        if ({ic_ack_o, ic_dat_o, dc_ack_o} !== {1'b1, 32'h0BADF00D, 1'b0})
            $display("FAIL second_ic_ack: got %b %h %b want 1 0badf00d 0", ic_ack_o, ic_dat_o, dc_ack_o);
        else n_pass++;
    endtask

    task automatic test_flush_fetch();
        apply_reset();
        issue_fetch(32'h180);
        tick();
        br_flag = 1; tick(); br_flag = 0;
        tick();
        mc_done_i = 1; mc_dat_i = 32'hCAFE0001; tick(); mc_done_i = 0;
        n_total++;
        if ({ic_ack_o, ic_dat_o} !== {1'b0, 32'h0})
            $display("FAIL flushed_fetch_no_ack: got %b %h want 0 0", ic_ack_o, ic_dat_o);
        else n_pass++;
        // back in IDLE: a load issues after the usual one-cycle capture
        dc_req_i = 1; dc_we_i = 0; dc_op_i = OP_LBU; dc_len_i = 3'd1; dc_adr_i = 32'h240;
        tick(); dc_req_i = 0; tick();
        n_total++;
        if ({mc_req_o, mc_adr_o, mc_op_o, mc_len_o} !== {1'b1, 32'h240, OP_LBU, 3'd1})
            $display("FAIL idle_after_squash: got %b %h %h %0d want 1 240 %h 1",
                     mc_req_o, mc_adr_o, mc_op_o, mc_len_o, OP_LBU);
        else n_pass++;
        // flush coinciding with completion of that load
        br_flag = 1; mc_done_i = 1; mc_dat_i = 32'h77; tick(); br_flag = 0; mc_done_i = 0;
        n_total++;
        if ({dc_ack_o, dc_dat_o, mc_req_o} !== {1'b0, 32'h0, 1'b0})
            $display("FAIL flush_at_done: got %b %h %b want 0 0 0", dc_ack_o, dc_dat_o, mc_req_o);
        else n_pass++;
    endtask

    task automatic test_flush_store();
        apply_reset();
        issue_fetch(32'h1C0);
        dc_req_i = 1; dc_we_i = 1; dc_op_i = OP_SW; dc_len_i = 3'd4;
        dc_adr_i = 32'h300; dc_dat_i = 32'hDEADBEEF;
        tick(); dc_req_i = 0; dc_we_i = 0;
        br_flag = 1; tick(); br_flag = 0;
        mc_done_i = 1; mc_dat_i = 32'h12345678; tick(); mc_done_i = 0;
        n_total++;
        if ({ic_ack_o, mc_req_o, mc_we_o, mc_op_o, mc_adr_o, mc_dat_o} !==
            {1'b0, 1'b1, 1'b1, OP_SW, 32'h300, 32'hDEADBEEF})
            $display("FAIL store_survives_flush: got %b %b %b %h %h %h want 0 1 1 %h 300 deadbeef",
                     ic_ack_o, mc_req_o, mc_we_o, mc_op_o, mc_adr_o, mc_dat_o, OP_SW);
        else n_pass++;
        tick();
        mc_done_i = 1; mc_dat_i = 32'h0; tick(); mc_done_i = 0;
        n_total++;
        if ({dc_ack_o, ic_ack_o} !== 2'b10)
            $display("FAIL store_ack: got %b %b want 1 0", dc_ack_o, ic_ack_o);
        else n_pass++;
    endtask

    task automatic test_reset_wait();
        apply_reset();
        issue_fetch(32'h1E0);
        tick();
        rst = 1; tick(); rst = 0;
        n_total++;
        if (dut_obs() !== obs_t'('0)) $display("FAIL reset_mid_wait: got %h want 0", dut_obs());
        else n_pass++;
        mc_done_i = 1; mc_dat_i = 32'h55; tick(); mc_done_i = 0; tick();
        n_total++;
        if ({ic_ack_o, dc_ack_o, mc_req_o, ic_dat_o} !== {3'b000, 32'h0})
            $display("FAIL stale_done: got %b %b %b %h want 0 0 0 0", ic_ack_o, dc_ack_o, mc_req_o, ic_dat_o);
        else n_pass++;
    endtask

    task automatic test_enable_freeze();
        apply_reset();
        issue_fetch(32'h1F0);
        en = 0; mc_done_i = 1; br_flag = 1; mc_dat_i = 32'h99; repeat (3) tick();
        n_total++;
        if ({mc_req_o, ic_ack_o, mc_adr_o} !== {1'b1, 1'b0, 32'h1F0})
            $display("FAIL freeze_hold: got %b %b %h want 1 0 1f0", mc_req_o, ic_ack_o, mc_adr_o);
        else n_pass++;
        en = 1; mc_done_i = 0; br_flag = 0; tick();
        mc_done_i = 1; mc_dat_i = 32'h0F0F0F0F; tick(); mc_done_i = 0;
        n_total++;
        if ({ic_ack_o, ic_dat_o} !== {1'b1, 32'h0F0F0F0F})
            $display("FAIL freeze_release_ack: got %b %h want 1 0f0f0f0f", ic_ack_o, ic_dat_o);
        else n_pass++;
    endtask

`ifdef STARVE_GUARD_EN
    task automatic test_starve_guard();
        int dc_g = 0;
        int cd   = 0;
        bit ic_seen = 0;
        apply_reset();
        ic_req_i = 1; ic_adr_i = 32'h500;
        dc_req_i = 1; dc_we_i = 0; dc_op_i = OP_LW; dc_len_i = 3'd4; dc_adr_i = 32'h400;
        tick(); ic_req_i = 0;
        for (int c = 0; c < 80 && !ic_seen; c++) begin
            mc_done_i = (cd == 1);
            if (cd > 0) cd--;
            tick();
            if (mc_req_o) begin
                cd = 3;
                if (mc_adr_o == 32'h500) ic_seen = 1; else dc_g++;
            end
            n_total++;
            if (dut_obs() !== m_out) $display("FAIL starve_model: got %h want %h", dut_obs(), m_out);
            else n_pass++;
        end
        n_total++;
        if (!ic_seen || dc_g != SMAX)
            $display("FAIL starve_guard: got ic_seen=%0d dc_grants=%0d want 1 %0d", ic_seen, dc_g, SMAX);
        else n_pass++;
        clear_inputs();
    endtask
`endif

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 2000; c++) begin
            rst       = ($urandom_range(0, 299) == 0);
            en        = ($urandom_range(0, 9) != 0);
            br_flag   = ($urandom_range(0, 9) == 0);
            ic_req_i  = ($urandom_range(0, 3) == 0);
            ic_adr_i  = $urandom;
            dc_req_i  = ($urandom_range(0, 3) == 0);
            dc_we_i   = $urandom_range(0, 1);
            dc_op_i   = dc_we_i ? OP_SB : OP_LH;
            dc_len_i  = 3'd1 << $urandom_range(0, 2);
            dc_adr_i  = $urandom;
            dc_dat_i  = $urandom;
            mc_done_i = ($urandom_range(0, 3) == 0);
            mc_dat_i  = $urandom;
            tick();
            n_total++;
            if (dut_obs() !== m_out)
                $display("FAIL random_cycle_%0d: got %h want %h", c, dut_obs(), m_out);
            else n_pass++;
        end
        clear_inputs(); rst = 0;
    endtask

    initial begin
        clear_inputs();
        rst = 1;
        test_reset();
        test_ic_fetch();
        test_same_cycle();
        test_flush_fetch();
        test_flush_store();
        test_reset_wait();
        test_enable_freeze();
`ifdef STARVE_GUARD_EN
        test_starve_guard();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Sits between the instruction-fetch unit (IC), the load/store data unit (DC) and the single byte-serial memory IO controller (MC).
- Latches one outstanding request per requester and grants the MC to one requester at a time. Only one MC transaction is ever in flight.
- Routes each completion back to the requester that issued it.
- On a branch flush, squashes fetches and loads. Stores are never dropped.

Parameters:
DAT_W, 32, address/data width
OP_W, 6, opcode field width (matches shared op encoding)
STARVE_MAX, 4, consecutive DC grants allowed while IC pending (STARVE_GUARD_EN only)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
en  in  1  global enable; low freezes all state, outputs hold
br_flag  in  1  branch mispredict flush
ic_req_i  in  1  IC fetch request pulse
ic_adr_i  in  DAT_W  fetch address
ic_ack_o  out  1  one-cycle fetch completion
ic_dat_o  out  DAT_W  fetched instruction
dc_req_i  in  1  DC request pulse
dc_we_i  in  1  1 store, 0 load
dc_op_i  in  OP_W  load/store opcode
dc_len_i  in  3  byte count 1/2/4
dc_adr_i  in  DAT_W  data address
dc_dat_i  in  DAT_W  store data
dc_ack_o  out  1  one-cycle DC completion
dc_dat_o  out  DAT_W  load result (extended by MC)
mc_req_o  out  1  one-cycle request to MC
mc_we_o  out  1  write enable to MC
mc_op_o  out  OP_W  opcode to MC (IC grant: LW code)
mc_len_o  out  3  length to MC (IC grant: 4)
mc_adr_o  out  DAT_W  address to MC
mc_dat_o  out  DAT_W  store data to MC
mc_done_i  in  1  MC completion pulse
mc_dat_i  in  DAT_W  MC read data

Behaviour:
- Reset state:
  - All outputs 0.
  - FSM state IDLE.
  - Both pending bits, the squash bit and the starvation counter cleared.
- Pending latches: ic_req_i or dc_req_i sets the matching pending bit and captures its fields.
  - A requester holds at most one outstanding request.
  - A req pulse while that requester is already pending is ignored.
- FSM states: IDLE, WAIT.
  - IDLE with any pending request: choose a winner.
    - DC wins over IC (unless overridden by the optional guard).
    - Drive mc_* from the winner's latch and pulse mc_req_o for one cycle.
    - Clear the winner's pending bit, record owner, go to WAIT.
  - A request captured in cycle t is issued at cycle t+1 at the earliest. The latch is bypassed only by registering; there is no combinational path req->mc_req_o.
  - WAIT with mc_done_i: register mc_dat_i into the owner's dat_o and pulse the owner's ack the following cycle. Return to IDLE.
    - A new grant may issue in the same cycle the ack pulses.
- mc_adr_o/mc_dat_o/mc_op_o/mc_len_o/mc_we_o hold their values throughout WAIT.
- br_flag:
  - Clears IC pending and clears a DC pending load.
  - A DC pending store is retained.
  - If the in-flight owner is IC, or DC with a load: set squash. The subsequent mc_done_i returns to IDLE with no ack and no dat update.
  - An in-flight store completes and acks normally.
- br_flag coinciding with ic_req_i: the request is discarded. Coinciding with a dc_req_i store: the store is captured.
- br_flag coinciding with mc_done_i of a fetch or load: no ack.
- mc_done_i in IDLE: ignored.
- en low: no state change, including the pending latches.

Optional Feature:
STARVE_GUARD_EN
- Defined:
  - A counter increments on each DC grant made while IC is pending.
  - It resets on an IC grant or when IC is not pending.
  - When the counter reaches STARVE_MAX, the next grant goes to IC even if DC is pending.
- Undefined: strict DC priority; no counter logic.

Decomposition:
- Shared package/header supplies:
  - DAT_W and OP_W.
  - Opcode constants (LW, SB, SH, SW, LB, LBU, LH, LHU).
  - The FSM state encoding constants and the owner encoding (OWN_IC=0, OWN_DC=1).
- One natural sub-module: req_latch.
  - Parameterised holder of pending bit plus address/data/op/len fields.
  - Instantiated once for IC and once for DC.

Test Plan:
- IC fetch alone:
  - Stimulus: ic_req_i adr 0x100, MC done after 5 cycles with 0x00112233.
  - Response: mc_req_o one cycle later with len 4, we 0; ic_ack_o one cycle after done; ic_dat_o=0x00112233.
- Same-cycle IC and DC requests:
  - Stimulus: ic_req_i with dc_req_i load adr 0x200.
  - Response: DC issued first; IC issued in the cycle dc_ack_o pulses.
- Flush during fetch:
  - Stimulus: br_flag while IC in flight.
  - Response: MC done produces no ic_ack_o; FSM returns to IDLE.
- Flush with pending store:
  - Stimulus: DC store 0xDEADBEEF to 0x300 pending behind an in-flight fetch, then br_flag.
  - Response: fetch squashed, then store issued with mc_we_o=1 and acked.
- Reset mid-WAIT:
  - Stimulus: rst asserted during WAIT.
  - Response: all outputs 0 next cycle; a later stale mc_done_i produces no ack.
- Starvation guard (STARVE_GUARD_EN, STARVE_MAX=4):
  - Stimulus: continuous DC requests with IC pending.
  - Response: IC granted after exactly 4 DC grants.
